// File: rtl/fp_addsub_pipe.sv
// Fully pipelined floating-point adder/subtractor (default binary16), round to nearest even.
// Input register, then align / add+LZC / normalise+round stages; result registered 3 clocks after in_En.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1+EXP_W+MAN_W-1:0] in_A,
  input  logic [1+EXP_W+MAN_W-1:0] in_B,
  input  logic                     in_Sub,
  input  logic                     in_En,
  output logic [1+EXP_W+MAN_W-1:0] out_Out,
  output logic                     out_Ready,
  output logic                     out_Overflow,
  output logic                     out_Underflow
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 4;          // {hidden, man, guard, round, sticky}
  localparam int unsigned WIDE_W = 2 * MAN_W + 4;
  localparam int unsigned LZ_W   = $clog2(SIG_W + 1);
  localparam int unsigned XE_W   = EXP_W + 2;
  localparam logic [EXP_W-1:0]      EXP_MAX = '1;
  localparam logic [W-1:0]          QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, (MAN_W-1)'(0)};
  localparam logic signed [XE_W-1:0] E_TOP  = XE_W'(2**EXP_W - 1);
  localparam logic signed [XE_W-1:0] E_ONE  = XE_W'(1);

  // ---------------- input register ----------------
  logic         s0_v, s0_sub;
  logic [W-1:0] s0_a, s0_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v <= 1'b0; s0_sub <= 1'b0; s0_a <= '0; s0_b <= '0;
    end else begin
      s0_v <= in_En; s0_sub <= in_Sub; s0_a <= in_A; s0_b <= in_B;
    end
  end

  // ---------------- stage 1: classify, swap, align ----------------
  logic               sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_ge;
  logic [EXP_W-1:0]   exp_a, exp_b, exp_x, exp_y, exp_d;
  logic [MAN_W-1:0]   man_a, man_b, man_x, man_y;
  logic               sign_x, sign_y, spec1;
  logic [W-1:0]       spec_val1;
  logic [WIDE_W-1:0]  y_wide;
  logic [SIG_W-1:0]   x_sig, y_al;

  always_comb begin
    sign_a = s0_a[W-1];
    exp_a  = s0_a[W-2:MAN_W];
    man_a  = s0_a[MAN_W-1:0];
    sign_b = s0_b[W-1] ^ s0_sub;
    exp_b  = s0_b[W-2:MAN_W];
    man_b  = s0_b[MAN_W-1:0];
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (exp_a == EXP_MAX) && (man_a == '0);
    inf_b  = (exp_b == EXP_MAX) && (man_b == '0);
    nan_a  = (exp_a == EXP_MAX) && (man_a != '0);
    nan_b  = (exp_b == EXP_MAX) && (man_b != '0);

    spec1     = 1'b1;
    spec_val1 = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) spec_val1 = QNAN;
    else if (inf_a)             spec_val1 = s0_a;
    else if (inf_b)             spec_val1 = {sign_b, s0_b[W-2:0]};
    else if (zero_a && zero_b)  spec_val1 = {sign_a & sign_b, (W-1)'(0)};
    else if (zero_a)            spec_val1 = {sign_b, s0_b[W-2:0]};
    else if (zero_b)            spec_val1 = s0_a;
    else                        spec1     = 1'b0;

    a_ge   = (s0_a[W-2:0] >= s0_b[W-2:0]);
    sign_x = a_ge ? sign_a : sign_b;
    sign_y = a_ge ? sign_b : sign_a;
    exp_x  = a_ge ? exp_a  : exp_b;
    exp_y  = a_ge ? exp_b  : exp_a;
    man_x  = a_ge ? man_a  : man_b;
    man_y  = a_ge ? man_b  : man_a;
    exp_d  = exp_x - exp_y;

    x_sig  = {1'b1, man_x, 3'b000};
    y_wide = {1'b1, man_y, (MAN_W+3)'(0)} >> exp_d;
    // Far-out shifts collapse to a lone sticky bit.
    if (32'(exp_d) >= MAN_W + 3) y_al = SIG_W'(1);
    else                         y_al = {y_wide[WIDE_W-1 -: SIG_W-1], |y_wide[MAN_W:0]};
  end

  logic               s1_v, s1_spec, s1_sign, s1_sub;
  logic [W-1:0]       s1_spec_val;
  logic [EXP_W-1:0]   s1_exp;
  logic [SIG_W-1:0]   s1_x, s1_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_spec <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_spec_val <= '0; s1_exp <= '0; s1_x <= '0; s1_y <= '0;
    end else begin
      s1_v        <= s0_v;
      s1_spec     <= spec1;
      s1_spec_val <= spec_val1;
      s1_sign     <= sign_x;
      s1_sub      <= sign_x ^ sign_y;
      s1_exp      <= exp_x;
      s1_x        <= x_sig;
      s1_y        <= y_al;
    end
  end

  // ---------------- stage 2: significand add/sub and leading-zero count ----------------
  logic [SIG_W:0]  sum;
  logic [LZ_W-1:0] lz;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
    lz  = LZ_W'(SIG_W);
    for (int i = 0; i < int'(SIG_W); i++) begin
      if (sum[i]) lz = LZ_W'(int'(SIG_W) - 1 - i);
    end
  end

  logic               s2_v, s2_spec, s2_sign;
  logic [W-1:0]       s2_spec_val;
  logic [EXP_W-1:0]   s2_exp;
  logic [SIG_W:0]     s2_sum;
  logic [LZ_W-1:0]    s2_lz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0; s2_spec <= 1'b0; s2_sign <= 1'b0; s2_spec_val <= '0;
      s2_exp <= '0; s2_sum <= '0; s2_lz <= '0;
    end else begin
      s2_v        <= s1_v;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      s2_lz       <= lz;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [SIG_W-1:0]         norm;
  logic signed [XE_W-1:0]   e_n, e_r;
  logic                     rnd_up;
  logic [MAN_W+1:0]         mant;
  logic [MAN_W-1:0]         man_r;
  logic [W-1:0]             res;
  logic                     ovf, unf;
  logic                     unused_hidden;

  always_comb begin
    if (s2_sum[SIG_W]) begin
      norm = {s2_sum[SIG_W:2], s2_sum[1] | s2_sum[0]};
      e_n  = $signed({2'b00, s2_exp}) + E_ONE;
    end else begin
      norm = s2_sum[SIG_W-1:0] << s2_lz;
      e_n  = $signed({2'b00, s2_exp}) - $signed(XE_W'(s2_lz));
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant   = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(rnd_up);
    // Rounding carry: significand becomes 1.000..., bump the exponent.
    e_r    = e_n + $signed(XE_W'(mant[MAN_W+1]));
    man_r  = mant[MAN_W+1] ? '0 : mant[MAN_W-1:0];
    unused_hidden = mant[MAN_W];

    ovf = 1'b0;
    unf = 1'b0;
    if (s2_spec) begin
      res = s2_spec_val;
    end else if (s2_sum == '0) begin
      res = '0;
    end else if (e_r >= E_TOP) begin
      res = {s2_sign, EXP_MAX, MAN_W'(0)};
      ovf = 1'b1;
    end else if (e_r < E_ONE) begin
      res = {s2_sign, (W-1)'(0)};
      unf = 1'b1;
    end else begin
      res = {s2_sign, e_r[EXP_W-1:0], man_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_Out <= '0; out_Ready <= 1'b0; out_Overflow <= 1'b0; out_Underflow <= 1'b0;
    end else begin
      out_Ready     <= s2_v;
      out_Overflow  <= s2_v & ovf;
      out_Underflow <= s2_v & unf;
      if (s2_v) out_Out <= res;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (binary16): directed spec vectors plus random stream
// compared against an exact integer-arithmetic reference with explicit RNE rounding.
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [15:0] r;
    logic        o;
    logic        u;
  } exp_t;

  logic        clk, rst, in_Sub, in_En;
  logic [15:0] in_A, in_B, out_Out;
  logic        out_Ready, out_Overflow, out_Underflow;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        q[$];
  logic [3:0]  hist;
  logic [15:0] last_out = 16'h0000;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_Sub(in_Sub), .in_En(in_En),
    .out_Out(out_Out), .out_Ready(out_Ready), .out_Overflow(out_Overflow),
    .out_Underflow(out_Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic o, input logic u);
    exp_t e;
    e.r = r; e.o = o; e.u = u;
    return e;
  endfunction

  // Exact reference: operands as integers in units of 2^-24, summed, then rounded RNE.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    exp_t   res;
    logic   sa, sb, sgn;
    int     ea, eb, p, sh, e;
    longint va, vb, s, mag, sig, rem, half;
    res = '0;
    sa = a[15]; sb = b[15] ^ sub;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0) || (ea == 31 && eb == 31 && sa != sb))
      res.r = 16'h7E00;
    else if (ea == 31)            res.r = a;
    else if (eb == 31)            res.r = {sb, b[14:0]};
    else if (ea == 0 && eb == 0)  res.r = {sa & sb, 15'd0};
    else if (ea == 0)             res.r = {sb, b[14:0]};
    else if (eb == 0)             res.r = a;
    else begin
      va = longint'({1'b1, a[9:0]}) << (ea - 1);
      vb = longint'({1'b1, b[9:0]}) << (eb - 1);
      if (sa) va = -va;
      if (sb) vb = -vb;
      s = va + vb;
      if (s != 0) begin
        sgn = (s < 0);
        mag = sgn ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        if (p < 10) begin
          res.r = {sgn, 15'd0};
          res.u = 1'b1;
        end else begin
          sh   = p - 10;
          sig  = mag >> sh;
          rem  = mag - (sig << sh);
          half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
          if (sh > 0 && (rem > half || (rem == half && sig[0]))) sig++;
          e = p - 9;
          if (sig == 2048) begin sig = 1024; e++; end
          if (e >= 31) begin
            res.r = {sgn, 5'h1f, 10'd0};
            res.o = 1'b1;
          end else begin
            res.r = {sgn, 5'(e), 10'(sig)};
          end
        end
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] rand_op();
    int         k;
    logic [4:0] e;
    logic [9:0] m;
    k = $urandom_range(0, 15);
    m = 10'($urandom);
    if (k == 0)      e = 5'd0;
    else if (k == 1) begin e = 5'h1f; if ($urandom_range(0, 1) == 1) m = 10'd0; end
    else if (k == 2) e = 5'd30;
    else if (k == 3) e = 5'd1;
    else             e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, m};
  endfunction

  // Latency reference: Ready follows in_En sampled three edges earlier.
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= 4'b0000;
    else     hist <= {hist[2:0], in_En};
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("ready", 32'(out_Ready), 32'(hist[3]));
      if (out_Ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("out", 32'(out_Out), 32'(e.r));
          check("ovf", 32'(out_Overflow), 32'(e.o));
          check("unf", 32'(out_Underflow), 32'(e.u));
          last_out = e.r;
        end
      end else begin
        check("flags_idle", 32'({out_Overflow, out_Underflow}), 32'd0);
        check("hold", 32'(out_Out), 32'(last_out));
      end
    end
  end

  // Called at posedge+1; presents one op for the next edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub, input exp_t e);
    in_A = a; in_B = b; in_Sub = sub; in_En = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    in_En = 1'b0;
  endtask

  task automatic issue_rand();
    logic [15:0] a, b;
    logic        sub;
    a   = rand_op();
    b   = ($urandom_range(0, 3) == 0) ? (a ^ 16'($urandom_range(0, 15))) : rand_op();
    sub = 1'($urandom);
    issue(a, b, sub, model(a, b, sub));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_En = 1'b0; in_Sub = 1'b0; in_A = 16'h0; in_B = 16'h0;
    #12;
    check("rst_ready", 32'(out_Ready), 32'd0);
    check("rst_out", 32'(out_Out), 32'd0);
    check("rst_flags", 32'({out_Overflow, out_Underflow}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(16'h5E40, 16'h6B2F, 1'b0, mk(16'h6BF7, 1'b0, 1'b0)); idle(4);
    issue(16'h6B2F, 16'h5E40, 1'b1, mk(16'h6A67, 1'b0, 1'b0)); idle(4);
    issue(16'h5E40, 16'h5E40, 1'b1, mk(16'h0000, 1'b0, 1'b0)); idle(4);
    issue(16'h6800, 16'h3C00, 1'b0, mk(16'h6800, 1'b0, 1'b0)); idle(4);
    issue(16'h6801, 16'h3C00, 1'b0, mk(16'h6802, 1'b0, 1'b0)); idle(4);
    issue(16'h7BFF, 16'h7BFF, 1'b0, mk(16'h7C00, 1'b1, 1'b0)); idle(4);
    issue(16'h7C00, 16'h7C00, 1'b1, mk(16'h7E00, 1'b0, 1'b0)); idle(4);
    issue(16'h7E00, 16'h3C00, 1'b0, mk(16'h7E00, 1'b0, 1'b0)); idle(4);
    issue(16'hFC00, 16'h3C00, 1'b0, mk(16'hFC00, 1'b0, 1'b0)); idle(4);
    issue(16'h0401, 16'h0400, 1'b1, mk(16'h0000, 1'b0, 1'b1)); idle(4);
    issue(16'h0400, 16'h0401, 1'b1, mk(16'h8000, 1'b0, 1'b1)); idle(4);
    issue(16'h0000, 16'h3C00, 1'b1, mk(16'hBC00, 1'b0, 1'b0)); idle(4);
    issue(16'h8000, 16'h8000, 1'b0, mk(16'h8000, 1'b0, 1'b0)); idle(4);
    issue(16'h4500, 16'h0000, 1'b1, mk(16'h4500, 1'b0, 1'b0)); idle(4);

    repeat (8) issue_rand();
    idle(5);

    // Reset while results are in flight: Ready must drop at once, nothing stale afterwards.
    repeat (5) issue_rand();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(out_Ready), 32'd0);
    check("midrst_out", 32'(out_Out), 32'd0);
    check("midrst_flags", 32'({out_Overflow, out_Underflow}), 32'd0);
    q.delete();
    last_out = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(6);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) issue_rand();
      else idle(1);
    end
    idle(6);
    check("drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
